wb_timer_ctrl: RTL and testbench

//  Wishbone master sequencer that configures and reads the 64-bit machine timer over its 32-bit slave port.

---
 rtl/wb_timer_ctrl_pkg.sv | 71 +++++++
 rtl/wb_timer_ctrl_single_master.sv | 97 +++++++++
 rtl/wb_timer_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_wb_timer_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_timer_ctrl_pkg
// Description : Shared definitions for the 64-bit machine-timer sequencer.
//               Provides the timer register offsets (LO/HI word pairs), the
//               command op codes, the MTIMECMP safe-high value, the sequencer
//               state encoding, and helpers that map a command and step index
//               to a bus address offset and write data word.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package wb_timer_ctrl_pkg;

    // Byte offsets of the timer slave registers, relative to TIMER_BASE
    localparam logic [31:0] c_mtime_lo    = 32'h0000_0000;
    localparam logic [31:0] c_mtime_hi    = 32'h0000_0004;
    localparam logic [31:0] c_mtimecmp_lo = 32'h0000_0008;
    localparam logic [31:0] c_mtimecmp_hi = 32'h0000_000C;
    localparam logic [31:0] c_tgt_clk_lo  = 32'h0000_0010;
    localparam logic [31:0] c_tgt_clk_hi  = 32'h0000_0014;

    // Parking MTIMECMP_LO here first means no intermediate compare value can
    // be at or below the running time while the HI word is being replaced.
    localparam logic [31:0] c_cmp_safe_hi = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_SET_CMP   = 2'd0,
        OP_SET_TGT   = 2'd1,
        OP_READ_TIME = 2'd2,
        OP_SET_TIME  = 2'd3
    } op_t;

    // GAP states are the mandatory bus-idle cycles; the next transaction is
    // launched from there so it starts right after the idle cycle.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_GAP = 3'd1,
        S_WR_REQ = 3'd2,
        S_RD_GAP = 3'd3,
        S_RD_REQ = 3'd4,
        S_RSP    = 3'd5
    } state_t;

    // Write sequence: LO (parking value), HI, LO (final value)
    function automatic logic [31:0] f_wr_offset(input op_t op, input logic [1:0] step);
        logic [31:0] v_lo;
        logic [31:0] v_hi;
        case (op)
            OP_SET_CMP: begin v_lo = c_mtimecmp_lo; v_hi = c_mtimecmp_hi; end
            OP_SET_TGT: begin v_lo = c_tgt_clk_lo;  v_hi = c_tgt_clk_hi;  end
            default:    begin v_lo = c_mtime_lo;    v_hi = c_mtime_hi;    end
        endcase
        return (step == 2'd1) ? v_hi : v_lo;
    endfunction

    function automatic logic [31:0] f_wr_data(input op_t op, input logic [1:0] step,
                                              input logic [63:0] data);
        case (step)
            2'd0:    return (op == OP_SET_CMP) ? c_cmp_safe_hi : 32'h0;
            2'd1:    return data[63:32];
            default: return data[31:0];
        endcase
    endfunction

    // Read sequence: HI, LO, HI
    function automatic logic [31:0] f_rd_offset(input logic [1:0] step);
        return (step == 2'd1) ? c_mtime_lo : c_mtime_hi;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_timer_ctrl_single_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_timer_ctrl_single_master
// Description : Runs one Wishbone transaction per start pulse.
//               Write: cyc/stb/we held with stable addr/data until ack, or
//               abort with err after ACK_TIMEOUT cycles without ack.
//               Read : cyc/stb high for exactly two cycles, read data passed
//               through combinationally and valid in the second cycle (done).
//               done_o/err_o are combinational and high in the last bus cycle;
//               cyc drops on the following edge.
// Ports       : clk_i, rst_n_i            clock, async active-low reset
//               start_i, we_i, addr_i, data_i   request (taken only when idle)
//               done_o, err_o, rdata_o     completion, timeout, read data
//               wbm_*                      Wishbone master bus
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timer_ctrl_single_master #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_data_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_data_i
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_rd_last  = CNT_W'(1);

    logic             r_cyc;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_cnt;     // cycles cyc has been high, minus one

    logic w_ack_done;
    logic w_timeout;
    logic w_rd_done;
    logic w_done;

    // An ack in the final allowed cycle still counts as success
    assign w_ack_done = r_cyc &  r_we & wbm_ack_i;
    assign w_timeout  = r_cyc &  r_we & ~wbm_ack_i & (r_cnt == c_cnt_last);
    assign w_rd_done  = r_cyc & ~r_we & (r_cnt == c_rd_last);
    assign w_done     = w_ack_done | w_timeout | w_rd_done;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_cnt   <= '0;
        end else if (!r_cyc) begin
            if (start_i) begin
                r_cyc   <= 1'b1;
                r_we    <= we_i;
                r_addr  <= addr_i;
                r_wdata <= we_i ? data_i : 32'h0;
                r_cnt   <= '0;
            end
        end else if (w_done) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign done_o     = w_done;
    assign err_o      = w_timeout;
    assign rdata_o    = wbm_data_i;
    assign wbm_addr_o = r_addr;
    assign wbm_data_o = r_wdata;
    assign wbm_we_o   = r_we;
    assign wbm_sel_o  = {4{r_cyc}};
    assign wbm_stb_o  = r_cyc;
    assign wbm_cyc_o  = r_cyc;

endmodule
`default_nettype wire

// File: rtl/wb_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_timer_ctrl
// Description : Wishbone master sequencer for the 64-bit machine timer.
//               Turns one 64-bit command into three 32-bit transactions:
//               SET_* writes LO(park), HI, LO(final) so no transient value is
//               seen by the timer; READ_TIME reads HI, LO, HI and retries up to
//               MAX_RETRY extra rounds while the HI words disagree.
//               Accept -> rsp_valid_o is 10 cycles with a 1-cycle ack.
// Ports       : clk_i, rst_n_i                   clock, async active-low reset
//               cmd_valid_i/cmd_ready_o/cmd_op_i/cmd_data_i   command port
//               rsp_valid_o/rsp_err_o/rsp_data_o  completion pulse and result
//               wbm_*                            Wishbone master to timer slave
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timer_ctrl
    import wb_timer_ctrl_pkg::*;
#(
    parameter logic [31:0] TIMER_BASE  = 32'h0,
    parameter int          ACK_TIMEOUT = 16,
    parameter int          MAX_RETRY   = 3
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [1:0]  cmd_op_i,
    input  logic [63:0] cmd_data_i,
    output logic        rsp_valid_o,
    output logic        rsp_err_o,
    output logic [63:0] rsp_data_o,
    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_data_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_data_i
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] c_retry_max = RETRY_W'(MAX_RETRY);

    state_t             r_state;
    state_t             w_state_nxt;
    op_t                r_op;
    logic [63:0]        r_data;
    logic [1:0]         r_step;    // index of next transaction; 3 = sequence done
    logic [RETRY_W-1:0] r_retry;
    logic [31:0]        r_hi0;
    logic [31:0]        r_lo;
    logic [31:0]        r_hi1;
    logic               r_err;
    logic [63:0]        r_rsp_data;

    logic        w_accept;
    logic        w_start;
    logic        w_we;
    logic        w_retry;
    logic        w_rd_finish;
    logic        w_match;
    logic [1:0]  w_step_sel;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_m_done;
    logic        w_m_err;
    logic [31:0] w_m_rdata;

    assign w_match    = (r_hi0 == r_hi1);
    assign w_we       = (r_op != OP_READ_TIME);
    // A retry relaunches from the HI read before r_step is rewound
    assign w_step_sel = w_retry ? 2'd0 : r_step;
    assign w_addr     = TIMER_BASE + (w_we ? f_wr_offset(r_op, w_step_sel)
                                           : f_rd_offset(w_step_sel));
    assign w_wdata    = w_we ? f_wr_data(r_op, w_step_sel, r_data) : 32'h0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_start     = 1'b0;
        w_retry     = 1'b0;
        w_rd_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (op_t'(cmd_op_i) == OP_READ_TIME) ? S_RD_GAP : S_WR_GAP;
                end
            end
            S_WR_GAP: begin
                if (r_step == 2'd3) begin
                    w_state_nxt = S_RSP;
                end else begin
                    w_start     = 1'b1;
                    w_state_nxt = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                // Timeout skips the remaining writes; earlier ones stay applied
                if (w_m_done) begin
                    w_state_nxt = w_m_err ? S_RSP : S_WR_GAP;
                end
            end
            S_RD_GAP: begin
                if (r_step == 2'd3) begin
                    if (w_match || (r_retry == c_retry_max)) begin
                        w_rd_finish = 1'b1;
                        w_state_nxt = S_RSP;
                    end else begin
                        w_retry     = 1'b1;
                        w_start     = 1'b1;
                        w_state_nxt = S_RD_REQ;
                    end
                end else begin
                    w_start     = 1'b1;
                    w_state_nxt = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (w_m_done) begin
                    w_state_nxt = S_RD_GAP;
                end
            end
            S_RSP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_op       <= OP_SET_CMP;
            r_data     <= 64'h0;
            r_step     <= 2'd0;
            r_retry    <= '0;
            r_hi0      <= 32'h0;
            r_lo       <= 32'h0;
            r_hi1      <= 32'h0;
            r_err      <= 1'b0;
            r_rsp_data <= 64'h0;
        end else begin
            if (w_accept) begin
                r_op       <= op_t'(cmd_op_i);
                r_data     <= cmd_data_i;
                r_step     <= 2'd0;
                r_retry    <= '0;
                r_err      <= 1'b0;
                r_rsp_data <= 64'h0;
            end
            if (w_retry) begin
                r_step  <= 2'd0;
                r_retry <= r_retry + RETRY_W'(1);
            end
            if (w_m_done) begin
                if (w_m_err) begin
                    r_err <= 1'b1;
                end else begin
                    r_step <= r_step + 2'd1;
                end
                if (!w_we) begin
                    case (r_step)
                        2'd0:    r_hi0 <= w_m_rdata;
                        2'd1:    r_lo  <= w_m_rdata;
                        default: r_hi1 <= w_m_rdata;
                    endcase
                end
            end
            if (w_rd_finish) begin
                r_rsp_data <= w_match ? {r_hi0, r_lo} : {r_hi1, r_lo};
                r_err      <= ~w_match;
            end
        end
    end

    wb_timer_ctrl_single_master #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_master (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .start_i    (w_start),
        .we_i       (w_we),
        .addr_i     (w_addr),
        .data_i     (w_wdata),
        .done_o     (w_m_done),
        .err_o      (w_m_err),
        .rdata_o    (w_m_rdata),
        .wbm_addr_o (wbm_addr_o),
        .wbm_data_o (wbm_data_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_data_i (wbm_data_i)
    );

    // Ready is gated by the reset pin so it reads low throughout reset
    assign cmd_ready_o = (r_state == S_IDLE) & rst_n_i;
    assign rsp_valid_o = (r_state == S_RSP);
    assign rsp_err_o   = (r_state == S_RSP) & r_err;
    assign rsp_data_o  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_timer_ctrl
// Description : Directed self-checking bench for wb_timer_ctrl. A small timer
//               slave model (registered ack, combinational reads, optional
//               no-ack / HI-word disturbance modes) plus a bus monitor that
//               logs completed writes, read transactions and cyc-high cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_timer_ctrl;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [63:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_err;
    logic [63:0] rsp_data;
    logic [31:0] wbm_addr;
    logic [31:0] wbm_wdata;
    logic        wbm_we;
    logic [3:0]  wbm_sel;
    logic        wbm_stb;
    logic        wbm_cyc;
    logic        wbm_ack = 1'b0;
    logic [31:0] wbm_rdata;

    always #5 clk = ~clk;

    wb_timer_ctrl #(
        .TIMER_BASE  (BASE),
        .ACK_TIMEOUT (16),
        .MAX_RETRY   (3)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_err_o   (rsp_err),
        .rsp_data_o  (rsp_data),
        .wbm_addr_o  (wbm_addr),
        .wbm_data_o  (wbm_wdata),
        .wbm_we_o    (wbm_we),
        .wbm_sel_o   (wbm_sel),
        .wbm_stb_o   (wbm_stb),
        .wbm_cyc_o   (wbm_cyc),
        .wbm_ack_i   (wbm_ack),
        .wbm_data_i  (wbm_rdata)
    );

    // ---------------- slave model and bus monitor ----------------
    // mode: 0 normal, 1 never ack, 2 HI toggles every HI read, 3 first HI read stale
    int          mode = 0;
    logic        init_regs = 1'b1;
    logic        clr_stats = 1'b1;
    logic [31:0] mem [0:7];
    logic [31:0] wr_addr [0:7];
    logic [31:0] wr_data [0:7];
    int          n_wr = 0;
    int          n_rd = 0;
    int          n_txn = 0;
    int          cyc_cycles = 0;
    int          hi_reads = 0;
    logic        irq_seen = 1'b0;
    logic        prev_cyc = 1'b0;
    logic [2:0]  s_idx;

    assign s_idx = wbm_addr[4:2];

    always @(posedge clk) begin
        wbm_ack  <= wbm_cyc & wbm_stb & wbm_we & (mode != 1);
        prev_cyc <= wbm_cyc;
        if (init_regs) begin
            mem[0] <= 32'h5;
            mem[1] <= 32'h0;
            mem[2] <= 32'hFFFF_FFFF;
            mem[3] <= 32'hFFFF_FFFF;
            mem[4] <= 32'h0;
            mem[5] <= 32'h0;
            mem[6] <= 32'h0;
            mem[7] <= 32'h0;
        end else if (wbm_cyc & wbm_we & wbm_ack) begin
            mem[s_idx] <= wbm_wdata;
        end
        if (clr_stats) begin
            n_wr       <= 0;
            n_rd       <= 0;
            n_txn      <= 0;
            cyc_cycles <= 0;
            hi_reads   <= 0;
            irq_seen   <= 1'b0;
        end else begin
            if (wbm_cyc & wbm_we & wbm_ack) begin
                if (n_wr < 8) begin
                    wr_addr[n_wr[2:0]] <= wbm_addr;
                    wr_data[n_wr[2:0]] <= wbm_wdata;
                end
                n_wr <= n_wr + 1;
            end
            if (wbm_cyc & ~prev_cyc) begin
                n_txn <= n_txn + 1;
                if (!wbm_we) begin
                    n_rd <= n_rd + 1;
                    if (s_idx == 3'd1) hi_reads <= hi_reads + 1;
                end
            end
            if (wbm_cyc) cyc_cycles <= cyc_cycles + 1;
            if ({mem[3], mem[2]} <= {mem[1], mem[0]}) irq_seen <= 1'b1;
        end
    end

    always_comb begin
        wbm_rdata = mem[s_idx];
        if (s_idx == 3'd1) begin
            if (mode == 2)
                wbm_rdata = mem[1] ^ {31'b0, hi_reads[0]};
            else if (mode == 3 && hi_reads == 1)
                wbm_rdata = mem[1] - 32'd1;
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        @(negedge clk);
        clr_stats = 1'b1;
        @(negedge clk);
        clr_stats = 1'b0;
    endtask

    // Issue one command; lat = cycles from accept edge to rsp_valid
    task automatic do_cmd(input logic [1:0] op, input logic [63:0] data,
                          output int lat, output logic err, output logic [63:0] rd);
        int   w;
        logic got;
        lat = -1; err = 1'b0; rd = 64'h0; got = 1'b0; w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("idle_ready", cmd_ready, 1);
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (c == 5) chk("busy_ready", cmd_ready, 0);
            if (rsp_valid) begin
                got = 1'b1;
                lat = c;
                err = rsp_err;
                rd  = rsp_data;
            end
        end
        chk("rsp_seen", got, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        logic        err;
        logic [63:0] rd;
        logic        saw;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = 64'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        init_regs = 1'b0;
        chk("rst_ready",     cmd_ready, 0);
        chk("rst_cyc",       wbm_cyc,   0);
        chk("rst_sel",       wbm_sel,   0);
        chk("rst_rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", cmd_ready, 1);
        clr_stats = 1'b0;

        // SET_CMP with mtime = 5
        clear_stats();
        do_cmd(2'd0, 64'h0000_0001_0000_0010, lat, err, rd);
        chk("cmp_lat",   64'(lat), 10);
        chk("cmp_err",   err, 0);
        chk("cmp_nwr",   64'(n_wr), 3);
        chk("cmp_a0",    wr_addr[0], BASE + 32'h08);
        chk("cmp_d0",    wr_data[0], 32'hFFFF_FFFF);
        chk("cmp_a1",    wr_addr[1], BASE + 32'h0C);
        chk("cmp_d1",    wr_data[1], 32'h1);
        chk("cmp_a2",    wr_addr[2], BASE + 32'h08);
        chk("cmp_d2",    wr_data[2], 32'h10);
        chk("cmp_irq",   irq_seen, 0);
        chk("cmp_nrd",   64'(n_rd), 0);

        // SET_TGT 4
        clear_stats();
        do_cmd(2'd1, 64'd4, lat, err, rd);
        chk("tgt_lat", 64'(lat), 10);
        chk("tgt_a0",  wr_addr[0], BASE + 32'h10);
        chk("tgt_d0",  wr_data[0], 32'h0);
        chk("tgt_a1",  wr_addr[1], BASE + 32'h14);
        chk("tgt_d2",  wr_data[2], 32'h4);

        // SET_TIME near a LO wrap
        clear_stats();
        do_cmd(2'd3, 64'h0000_0002_FFFF_FFFE, lat, err, rd);
        chk("time_err", err, 0);
        chk("time_a0",  wr_addr[0], BASE + 32'h00);
        chk("time_d0",  wr_data[0], 32'h0);
        chk("time_a1",  wr_addr[1], BASE + 32'h04);
        chk("time_d1",  wr_data[1], 32'h2);
        chk("time_d2",  wr_data[2], 32'hFFFF_FFFE);

        // Clean READ_TIME
        clear_stats();
        do_cmd(2'd2, 64'hDEAD_BEEF_0000_0000, lat, err, rd);
        chk("rd_lat",  64'(lat), 10);
        chk("rd_err",  err, 0);
        chk("rd_data", rd, 64'h0000_0002_FFFF_FFFE);
        chk("rd_nrd",  64'(n_rd), 3);
        chk("rd_nwr",  64'(n_wr), 0);

        // First HI read stale: one retry then success
        mode = 3;
        clear_stats();
        do_cmd(2'd2, 64'h0, lat, err, rd);
        chk("retry1_lat",  64'(lat), 19);
        chk("retry1_err",  err, 0);
        chk("retry1_data", rd, 64'h0000_0002_FFFF_FFFE);
        chk("retry1_nrd",  64'(n_rd), 6);

        // HI toggles forever: 4 rounds then error with {h1,l}
        mode = 2;
        clear_stats();
        do_cmd(2'd2, 64'h0, lat, err, rd);
        chk("retryx_lat",  64'(lat), 37);
        chk("retryx_err",  err, 1);
        chk("retryx_data", rd, 64'h0000_0002_FFFF_FFFE);
        chk("retryx_nrd",  64'(n_rd), 12);

        // No ack: timeout after 16 cyc-high cycles, one write attempted
        mode = 1;
        clear_stats();
        do_cmd(2'd0, 64'h1234_5678_9ABC_DEF0, lat, err, rd);
        chk("to_lat",    64'(lat), 17);
        chk("to_err",    err, 1);
        chk("to_cycles", 64'(cyc_cycles), 16);
        chk("to_ntxn",   64'(n_txn), 1);
        chk("to_nwr",    64'(n_wr), 0);

        // Reset in cycle 2 of SET_CMP
        mode = 0;
        clear_stats();
        @(negedge clk);
        cmd_op    = 2'd0;
        cmd_data  = 64'h0000_0001_0000_0010;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_cyc_before", wbm_cyc, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_cyc_drop", wbm_cyc,   0);
        chk("mid_ready",    cmd_ready, 0);
        saw = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid) saw = 1'b1;
        end
        chk("mid_no_rsp", saw, 0);
        rst_n = 1'b1;
        clear_stats();
        do_cmd(2'd0, 64'h0000_0001_0000_0010, lat, err, rd);
        chk("post_lat", 64'(lat), 10);
        chk("post_err", err, 0);
        chk("post_nwr", 64'(n_wr), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
